// File: rtl/lector_contador_pkg.sv
// Shared definitions for the contador readout sequencer.
// State encodings and default sizing used by lector_contador and its bench.
package lector_contador_pkg;

    localparam int unsigned LC_NUM_FIFOS = 5;
    localparam int unsigned LC_DATA_W    = 5;
    localparam int unsigned LC_IDX_W     = 3;
    localparam int unsigned LC_TIMEOUT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/lector_contador.sv
// Readout sequencer: walks idx 0..NUM_FIFOS-1 on contador, captures each count
// and publishes all of them as one atomic snapshot with a per-slot timeout mask.
module lector_contador
    import lector_contador_pkg::*;
#(
    parameter int unsigned NUM_FIFOS = LC_NUM_FIFOS,
    parameter int unsigned DATA_W    = LC_DATA_W,
    parameter int unsigned IDX_W     = LC_IDX_W,
    parameter int unsigned TIMEOUT   = LC_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          valid_in,
    output logic                          req,
    output logic [IDX_W-1:0]              idx,
    output logic [NUM_FIFOS*DATA_W-1:0]   counts,
    output logic [NUM_FIFOS-1:0]          err_mask,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned         TMR_W    = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_FIFOS - 1);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t                         r_state;
    logic [IDX_W-1:0]               r_cur;
    logic [TMR_W-1:0]               r_timer;
    logic [NUM_FIFOS*DATA_W-1:0]    r_shadow;
    logic [NUM_FIFOS-1:0]           r_shadow_err;
    logic                           r_req;
    logic [IDX_W-1:0]               r_idx;
    logic [NUM_FIFOS*DATA_W-1:0]    r_counts;
    logic [NUM_FIFOS-1:0]           r_err_mask;
    logic                           r_busy;
    logic                           r_done;

    logic                           w_slot_end;
    logic                           w_slot_err;
    logic [DATA_W-1:0]              w_slot_data;
    logic [NUM_FIFOS*DATA_W-1:0]    w_shadow_next;
    logic [NUM_FIFOS-1:0]           w_err_next;

    // Slot outcome for the current index: captured value, or timeout failure.
    always_comb begin
        w_slot_end  = 1'b0;
        w_slot_err  = 1'b0;
        w_slot_data = '0;
        case (r_state)
            ST_REQ: begin
                if (valid_in) begin
                    w_slot_end  = 1'b1;
                    w_slot_data = data_in;
                end
            end
            ST_WAIT: begin
                if (valid_in) begin
                    w_slot_end  = 1'b1;
                    w_slot_data = data_in;
                end else if (r_timer == TMR_LAST) begin
                    w_slot_end = 1'b1;
                    w_slot_err = 1'b1;
                end
            end
            default: ;
        endcase

        w_shadow_next = r_shadow;
        w_err_next    = r_shadow_err;
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
            if (IDX_W'(k) == r_cur) begin
                w_shadow_next[k*DATA_W +: DATA_W] = w_slot_data;
                w_err_next[k]                     = w_slot_err;
            end
        end
    end

    // The snapshot is loaded on the edge entering DONE so that counts and
    // done become visible together in the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cur        <= '0;
            r_timer      <= '0;
            r_shadow     <= '0;
            r_shadow_err <= '0;
            r_req        <= 1'b0;
            r_idx        <= '0;
            r_counts     <= '0;
            r_err_mask   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_REQ;
                        r_cur        <= '0;
                        r_idx        <= '0;
                        r_timer      <= '0;
                        r_shadow     <= '0;
                        r_shadow_err <= '0;
                        r_req        <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (w_slot_end) begin
                        r_shadow     <= w_shadow_next;
                        r_shadow_err <= w_err_next;
                        if (r_cur == LAST_IDX) begin
                            r_state    <= ST_DONE;
                            r_req      <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_counts   <= w_shadow_next;
                            r_err_mask <= w_err_next;
                        end else begin
                            r_state <= ST_REQ;
                            r_cur   <= r_cur + 1'b1;
                            r_idx   <= r_cur + 1'b1;
                            r_req   <= 1'b1;
                        end
                    end else if (r_state == ST_REQ) begin
                        r_state <= ST_WAIT;
                        r_timer <= '0;
                        r_req   <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req      = r_req;
    assign idx      = r_idx;
    assign counts   = r_counts;
    assign err_mask = r_err_mask;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_lector_contador.sv
// Scoreboard bench for lector_contador with a behavioural contador responder.
// Expected snapshots are queued at stimulus time and popped on each done pulse.
module tb_lector_contador;

    localparam int unsigned NF = 5;
    localparam int unsigned DW = 5;
    localparam int unsigned IW = 3;

    typedef struct {
        logic [NF*DW-1:0] counts;
        logic [NF-1:0]    err;
        int               cyc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [DW-1:0]     data_in;
    logic              valid_in;
    logic              req;
    logic [IW-1:0]     idx;
    logic [NF*DW-1:0]  counts;
    logic [NF-1:0]     err_mask;
    logic              busy;
    logic              done;

    lector_contador #(
        .NUM_FIFOS(NF),
        .DATA_W   (DW),
        .IDX_W    (IW),
        .TIMEOUT  (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .valid_in(valid_in),
        .req     (req),
        .idx     (idx),
        .counts  (counts),
        .err_mask(err_mask),
        .busy    (busy),
        .done    (done)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   start_cyc;
    exp_t exp_q[$];

    logic          model_en   = 1'b0;
    logic          same_cycle = 1'b0;
    logic [NF-1:0] silent     = '0;
    logic [DW-1:0] resp [NF];
    logic          man_valid  = 1'b0;
    logic [DW-1:0] man_data   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // contador responder: answers either in the req cycle or the cycle after
    initial begin
        logic          prev_req;
        logic [IW-1:0] prev_idx;
        prev_req = 1'b0;
        prev_idx = '0;
        valid_in = 1'b0;
        data_in  = '0;
        forever begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            data_in  = '0;
            if (!model_en) begin
                valid_in = man_valid;
                data_in  = man_data;
            end else if (same_cycle) begin
                if (req && !silent[idx]) begin
                    valid_in = 1'b1;
                    data_in  = resp[idx];
                end
            end else if (prev_req && !silent[prev_idx]) begin
                valid_in = 1'b1;
                data_in  = resp[prev_idx];
            end
            prev_req = req;
            prev_idx = idx;
        end
    end

    // monitor: every done pulse must match the oldest queued snapshot
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("counts", 64'(counts), 64'(e.counts));
                    check("err_mask", 64'(err_mask), 64'(e.err));
                    if (e.cyc != 0) check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic push_exp(input logic [NF*DW-1:0] c, input logic [NF-1:0] e, input int at);
        exp_t x;
        x.counts = c;
        x.err    = e;
        x.cyc    = at;
        exp_q.push_back(x);
    endtask

    // Leaves the caller just after the edge that sampled start (cycle 1 begins).
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) check("wait_done_timeout", 64'd1, 64'd0);
    endtask

    task automatic set_resp(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                            input logic [DW-1:0] d, input logic [DW-1:0] e);
        resp[0] = a; resp[1] = b; resp[2] = c; resp[3] = d; resp[4] = e;
    endtask

    initial begin
        int wait2;
        logic seen_busy;
        reset = 1'b1;
        start = 1'b0;
        set_resp(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_req", 64'(req), 64'd0);
        check("rst_idx", 64'(idx), 64'd0);
        check("rst_counts", 64'(counts), 64'd0);
        check("rst_err", 64'(err_mask), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        model_en = 1'b1;
        repeat (2) @(negedge clk);

        // nominal: valid one cycle after req
        set_resp(3, 0, 31, 7, 1);
        do_start();
        push_exp({5'd1, 5'd7, 5'd31, 5'd0, 5'd3}, 5'b00000, start_cyc + 10);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check("nom_req", 64'(req), 64'((c <= 10) && (c % 2 == 1)));
            if (c <= 10) check("nom_idx", 64'(idx), 64'((c - 1) / 2));
            check("nom_busy", 64'(busy), 64'(c <= 10));
        end
        repeat (2) @(negedge clk);

        // same-cycle valid: one cycle per slot
        same_cycle = 1'b1;
        set_resp(5, 5, 5, 5, 5);
        do_start();
        push_exp({5{5'd5}}, 5'b00000, start_cyc + 5);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("same_req", 64'(req), 64'(c <= 5));
            if (c <= 5) check("same_idx", 64'(idx), 64'(c - 1));
        end
        same_cycle = 1'b0;
        repeat (2) @(negedge clk);

        // timeout on idx 2
        silent = 5'b00100;
        set_resp(4, 4, 4, 4, 4);
        do_start();
        push_exp({5'd4, 5'd4, 5'd0, 5'd4, 5'd4}, 5'b00100, start_cyc + 13);
        wait2 = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (busy && !req && idx == 3'd2) wait2++;
            if (c == 10) begin
                check("to_req_idx3", 64'(req), 64'd1);
                check("to_idx3", 64'(idx), 64'd3);
            end
        end
        check("to_wait_len", 64'(wait2), 64'd4);
        silent = '0;
        repeat (2) @(negedge clk);

        // start pulsed while busy is dropped
        set_resp(1, 2, 3, 4, 5);
        do_start();
        push_exp({5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 5'b00000, start_cyc + 10);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = (c == 4);
        end
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("ignored_start_idle", 64'(busy), 64'd0);

        // start held high: back-to-back readouts
        push_exp({5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 5'b00000, 0);
        push_exp({5'd10, 5'd9, 5'd8, 5'd7, 5'd6}, 5'b00000, 0);
        @(negedge clk);
        start = 1'b1;
        wait_done(30);
        set_resp(6, 7, 8, 9, 10);
        seen_busy = 1'b0;
        for (int i = 0; i < 5 && !seen_busy; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("held_restart", 64'(seen_busy), 64'd1);
        start = 1'b0;
        wait_done(30);
        repeat (2) @(negedge clk);

        // reset during WAIT of idx 3
        set_resp(2, 2, 2, 2, 2);
        do_start();
        for (int c = 1; c <= 8; c++) @(negedge clk);
        check("mid_wait_idx3", 64'({busy, req, idx}), 64'({1'b1, 1'b0, 3'd3}));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 64'(req), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_counts", 64'(counts), 64'd0);
        check("mid_rst_err", 64'(err_mask), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        set_resp(10, 11, 12, 13, 14);
        do_start();
        push_exp({5'd14, 5'd13, 5'd12, 5'd11, 5'd10}, 5'b00000, start_cyc + 10);
        wait_done(20);
        repeat (2) @(negedge clk);

        // stale valid while idle
        model_en  = 1'b0;
        man_valid = 1'b1;
        man_data  = 5'd9;
        repeat (4) @(negedge clk);
        man_valid = 1'b0;
        man_data  = '0;
        repeat (3) @(negedge clk);
        check("stale_counts", 64'(counts), 64'({5'd14, 5'd13, 5'd12, 5'd11, 5'd10}));
        check("stale_err", 64'(err_mask), 64'd0);
        check("stale_busy", 64'(busy), 64'd0);
        model_en = 1'b1;

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
